// File: rtl/acc_pila.sv
// ---------------------------------------------------------------------------
// acc_pila: datapath accumulator that supports in-place arithmetic, a PROF-deep
// save/restore stack and a sticky stack-misuse indicator.
//
// Parameters:
//   DB    data width in bits (>= 2)
//   PROF  stack depth in entries (power of two, >= 2)
//
// Ports:
//   clk       rising-edge clock
//   Reset     synchronous, active-high; clears all state
//   Entrada   operand bus (DB bits)
//   WrAcc     operation strobe; Op executes only on edges where it is 1
//   Op        000 nop, 001 load, 010 add, 011 sub, 100 clear,
//             101 push, 110 pop, 111 swap
//   Salida    registered accumulator value (DB bits)
//   Nivel     stack occupancy, 0..PROF
//   Vacia     Nivel == 0
//   Llena     Nivel == PROF
//   Error     sticky misuse flag: push when full, or pop/swap when empty.
//             It is cleared by clear or Reset.
//   Cero, Negativo, Acarreo, Desborde  status flags
//
// Optional feature: define ACC_PILA_FLAGS_EN to register the status flags.
// When the macro is not defined, the four flag ports stay present and are
// tied to 0.
// ---------------------------------------------------------------------------
module acc_pila #(
  parameter  int DB   = 16,
  parameter  int PROF = 4,
  localparam int NW   = $clog2(PROF + 1)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic [DB-1:0] Entrada,
  input  logic          WrAcc,
  input  logic [2:0]    Op,
  output logic [DB-1:0] Salida,
  output logic [NW-1:0] Nivel,
  output logic          Vacia,
  output logic          Llena,
  output logic          Error,
  output logic          Cero,
  output logic          Negativo,
  output logic          Acarreo,
  output logic          Desborde
);

  localparam int AW = $clog2(PROF);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_CLEAR = 3'b100,
    OP_PUSH  = 3'b101,
    OP_POP   = 3'b110,
    OP_SWAP  = 3'b111
  } op_e;

  op_e             w_op;
  logic [DB-1:0]   r_acc;
  logic [NW-1:0]   r_nivel;
  logic            r_error;
  logic [DB-1:0]   r_pila [PROF];

  logic            w_vacia;
  logic            w_llena;
  logic [AW-1:0]   w_top_idx;
  logic [DB-1:0]   w_acc_nxt;
  logic            w_acc_we;
  logic [NW-1:0]   w_nivel_nxt;
  logic            w_err_nxt;
  logic            w_st_we;
  logic [AW-1:0]   w_st_addr;
  logic [DB-1:0]   w_st_data;

  assign w_op      = op_e'(Op);
  assign w_vacia   = (r_nivel == '0);
  assign w_llena   = (r_nivel == NW'(PROF));
  // The top entry sits one below the occupancy count.
  assign w_top_idx = AW'(r_nivel - NW'(1));

  // When flags are enabled, the add/sub results carry one extra bit that
  // holds the carry/borrow.
`ifdef ACC_PILA_FLAGS_EN
  logic [DB:0]   w_sum;
  logic [DB:0]   w_dif;
  assign w_sum = {1'b0, r_acc} + {1'b0, Entrada};
  assign w_dif = {1'b0, r_acc} - {1'b0, Entrada};
`else
  logic [DB-1:0] w_sum;
  logic [DB-1:0] w_dif;
  assign w_sum = r_acc + Entrada;
  assign w_dif = r_acc - Entrada;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case; otherwise, paths
    // that do not assign it would infer a latch.
    w_acc_nxt   = r_acc;
    w_acc_we    = 1'b0;
    w_nivel_nxt = r_nivel;
    w_err_nxt   = r_error;
    w_st_we     = 1'b0;
    w_st_addr   = w_top_idx;
    w_st_data   = r_acc;
    if (WrAcc) begin
      case (w_op)
        OP_LOAD: begin
          w_acc_nxt = Entrada;
          w_acc_we  = 1'b1;
        end
        OP_ADD: begin
          w_acc_nxt = w_sum[DB-1:0];
          w_acc_we  = 1'b1;
        end
        OP_SUB: begin
          w_acc_nxt = w_dif[DB-1:0];
          w_acc_we  = 1'b1;
        end
        OP_CLEAR: begin
          w_acc_nxt = '0;
          w_acc_we  = 1'b1;
          w_err_nxt = 1'b0;
        end
        OP_PUSH: begin
          if (w_llena) begin
            w_err_nxt = 1'b1;
          end else begin
            // Nivel < PROF here, so its low bits address the free slot.
            w_st_we     = 1'b1;
            w_st_addr   = r_nivel[AW-1:0];
            w_nivel_nxt = r_nivel + NW'(1);
          end
        end
        OP_POP: begin
          if (w_vacia) begin
            w_err_nxt = 1'b1;
          end else begin
            w_acc_nxt   = r_pila[w_top_idx];
            w_acc_we    = 1'b1;
            w_nivel_nxt = r_nivel - NW'(1);
          end
        end
        OP_SWAP: begin
          if (w_vacia) begin
            w_err_nxt = 1'b1;
          end else begin
            w_acc_nxt = r_pila[w_top_idx];
            w_acc_we  = 1'b1;
            w_st_we   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop
  // samples the values present before the edge.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_acc   <= '0;
      r_nivel <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_acc_we) r_acc <= w_acc_nxt;
      r_nivel <= w_nivel_nxt;
      r_error <= w_err_nxt;
    end
  end

  // NOTE: stack storage is deliberately not reset. Its contents are
  // unreachable once Nivel returns to 0.
  always_ff @(posedge clk) begin
    if (!Reset && w_st_we) r_pila[w_st_addr] <= w_st_data;
  end

`ifdef ACC_PILA_FLAGS_EN
  logic r_cero;
  logic r_negativo;
  logic r_acarreo;
  logic r_desborde;
  logic w_is_add;
  logic w_is_sub;
  logic w_ovf_add;
  logic w_ovf_sub;

  assign w_is_add  = WrAcc && (w_op == OP_ADD);
  assign w_is_sub  = WrAcc && (w_op == OP_SUB);
  // Signed overflow: add overflows when same-sign operands give a result
  // of the other sign; sub overflows when operands of differing sign do.
  assign w_ovf_add = (r_acc[DB-1] == Entrada[DB-1]) && (w_sum[DB-1] != r_acc[DB-1]);
  assign w_ovf_sub = (r_acc[DB-1] != Entrada[DB-1]) && (w_dif[DB-1] != r_acc[DB-1]);

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_cero     <= 1'b0;
      r_negativo <= 1'b0;
      r_acarreo  <= 1'b0;
      r_desborde <= 1'b0;
    end else if (w_acc_we) begin
      r_cero     <= (w_acc_nxt == '0);
      r_negativo <= w_acc_nxt[DB-1];
      r_acarreo  <= (w_is_add && w_sum[DB]) || (w_is_sub && w_dif[DB]);
      r_desborde <= (w_is_add && w_ovf_add) || (w_is_sub && w_ovf_sub);
    end
  end

  assign Cero     = r_cero;
  assign Negativo = r_negativo;
  assign Acarreo  = r_acarreo;
  assign Desborde = r_desborde;
`else
  assign Cero     = 1'b0;
  assign Negativo = 1'b0;
  assign Acarreo  = 1'b0;
  assign Desborde = 1'b0;
`endif

  assign Salida = r_acc;
  assign Nivel  = r_nivel;
  assign Vacia  = w_vacia;
  assign Llena  = w_llena;
  assign Error  = r_error;

endmodule
